// File: rtl/ffe_pkg.sv
`default_nettype none
// ============================================================================
// ffe_pkg : shared FFE constants, controller state encoding, tap-count clamp
// Rev 1.0
// ============================================================================
package ffe_pkg;

  localparam int unsigned FFE_MAX_TAPS = 8;
  localparam int unsigned FFE_CNT_W    = 16;

  typedef enum logic [0:0] {
    L_IDLE = 1'b0,
    L_RUN  = 1'b1
  } ffe_state_t;

  // Zero or out-of-range tap counts fall back to the full filter length
  function automatic int unsigned clamp_taps(input int unsigned taps,
                                             input int unsigned max_taps);
    return ((taps == 0) || (taps > max_taps)) ? max_taps : taps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ffe_tap_sequencer_if.sv
`default_nettype none
// ============================================================================
// ffe_tap_sequencer_if : sample handshake, config and MAC control bundle
// Rev 1.0
// ============================================================================
interface ffe_tap_sequencer_if
  import ffe_pkg::*;
#(
  parameter int MAX_TAPS = FFE_MAX_TAPS,
  parameter int CNT_W    = FFE_CNT_W
) ();

  localparam int ADDR_SIZE = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;

  logic                 load;
  logic [ADDR_SIZE:0]   cfg_taps;
  logic                 in_valid;
  logic                 in_ready;
  logic                 shift_en;
  logic                 acc_dump;
  logic                 out_valid;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 busy;
  logic [CNT_W-1:0]     sym_cnt;

  modport master (
    output load, cfg_taps, in_valid,
    input  in_ready, shift_en, acc_dump, out_valid, rd_addr, busy, sym_cnt
  );

  modport slave (
    input  load, cfg_taps, in_valid,
    output in_ready, shift_en, acc_dump, out_valid, rd_addr, busy, sym_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ffe_tap_sequencer.sv
`default_nettype none
// ============================================================================
// ffe_tap_sequencer : walks the FFE tap address, emits shift/dump strobes
// Rev 1.0
// ============================================================================
module ffe_tap_sequencer
  import ffe_pkg::*;
#(
  parameter int MAX_TAPS  = FFE_MAX_TAPS,
  parameter int ADDR_SIZE = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1,
  parameter int CNT_W     = FFE_CNT_W
) (
  input  wire logic ffe_clk,
  input  wire logic rst,
  ffe_tap_sequencer_if.slave bus
);

  localparam int TAP_W = ADDR_SIZE + 1;

  ffe_state_t           state_q, state_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [TAP_W-1:0]     n_q, n_d;
  logic                 primed_q, primed_d;
  logic [CNT_W-1:0]     sym_cnt_q, sym_cnt_d;

  logic                 shift_w;
  logic                 dump_w;
  logic [TAP_W-1:0]     addr_ext_w;
  logic [TAP_W-1:0]     n_m1_w;
  logic                 at_zero_w;
  logic                 at_last_w;
  logic                 addr_oob_w;

  assign addr_ext_w = {1'b0, rd_addr_q};
  assign n_m1_w     = n_q - TAP_W'(1);
  assign at_zero_w  = (rd_addr_q == '0);
  assign at_last_w  = (addr_ext_w == n_m1_w);
  assign addr_oob_w = (addr_ext_w >= n_q);

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    n_d       = n_q;
    primed_d  = primed_q;
    sym_cnt_d = sym_cnt_q;
    shift_w   = 1'b0;
    dump_w    = 1'b0;

    case (state_q)
      L_IDLE: begin
        rd_addr_d = '0;
        primed_d  = 1'b0;
        if (bus.load) begin
          state_d = L_RUN;
          n_d     = TAP_W'(clamp_taps(32'(bus.cfg_taps), 32'(MAX_TAPS)));
        end
      end

      L_RUN: begin
        if (addr_oob_w) begin
          rd_addr_d = '0;
        end else if (at_zero_w) begin
          if (bus.in_valid) begin
            shift_w   = 1'b1;
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
            rd_addr_d = n_m1_w[ADDR_SIZE-1:0];
            // With a single tap the shift cycle also ends the symbol
            if ((n_q == TAP_W'(1)) && !bus.load) begin
              state_d = L_IDLE;
            end
          end else if (!bus.load) begin
            state_d = L_IDLE;
          end
        end else if (rd_addr_q == ADDR_SIZE'(1)) begin
          rd_addr_d = '0;
          if (!bus.load) begin
            state_d = L_IDLE;
          end
        end else begin
          rd_addr_d = rd_addr_q - ADDR_SIZE'(1);
        end

        // At address 0 (N=1) the dump rides on the shift, so a stall blocks it
        if (!addr_oob_w && at_last_w && (!at_zero_w || bus.in_valid)) begin
          dump_w   = 1'b1;
          primed_d = 1'b1;
        end
      end

      default: begin
        state_d   = L_IDLE;
        rd_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= L_IDLE;
      rd_addr_q <= '0;
      n_q       <= TAP_W'(MAX_TAPS);
      primed_q  <= 1'b0;
      sym_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      n_q       <= n_d;
      primed_q  <= primed_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  assign bus.shift_en  = shift_w;
  assign bus.in_ready  = shift_w;
  assign bus.acc_dump  = dump_w;
  assign bus.out_valid = dump_w & primed_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.busy      = (state_q == L_RUN);
  assign bus.sym_cnt   = sym_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ffe_tap_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ffe_tap_sequencer : directed self-checking bench for ffe_tap_sequencer
// Rev 1.0
// ============================================================================
module tb_ffe_tap_sequencer;

  localparam int MAX_TAPS = 8;
  localparam int CNT_W    = 16;

  logic ffe_clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  ffe_tap_sequencer_if #(.MAX_TAPS(MAX_TAPS), .CNT_W(CNT_W)) bus ();

  ffe_tap_sequencer #(.MAX_TAPS(MAX_TAPS), .CNT_W(CNT_W)) dut (
    .ffe_clk (ffe_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial ffe_clk = 1'b0;
  always #5 ffe_clk = ~ffe_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are set at posedge+1; strobes are checked at posedge+2
  task automatic cyc(input string tag, input int addr, input bit sh, input bit dp, input bit ov);
    #1;
    chk({tag, ".rd_addr"},   32'(bus.rd_addr),   32'(addr));
    chk({tag, ".shift_en"},  32'(bus.shift_en),  32'(sh));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(sh));
    chk({tag, ".acc_dump"},  32'(bus.acc_dump),  32'(dp));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    @(posedge ffe_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rd_addr"},   32'(bus.rd_addr),   0);
    chk({tag, ".shift_en"},  32'(bus.shift_en),  0);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  0);
    chk({tag, ".acc_dump"},  32'(bus.acc_dump),  0);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, ".busy"},      32'(bus.busy),      0);
    chk({tag, ".sym_cnt"},   32'(bus.sym_cnt),   0);
  endtask

  initial begin
    int c_addr4 [4];
    c_addr4  = '{0, 3, 2, 1};
    n_assert = 0;
    n_fail   = 0;

    rst          = 1'b0;
    bus.load     = 1'b0;
    bus.cfg_taps = 4'd4;
    bus.in_valid = 1'b1;

    // Reset state
    #2;
    chk_all_zero("reset0");
    @(posedge ffe_clk);
    #1;
    chk_all_zero("reset1");

    // N=4, continuous input
    rst      = 1'b1;
    bus.load = 1'b1;
    chk("idle.busy", 32'(bus.busy), 0);
    cyc("idle", 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc("n4run", c_addr4[i % 4], (i % 4) == 0, (i % 4) == 1, ((i % 4) == 1) && (i >= 5));
    end
    chk("n4.sym_cnt", 32'(bus.sym_cnt), 5);
    chk("n4.busy", 32'(bus.busy), 1);

    // Stall three cycles at address 0
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("stall", 0, 0, 0, 0);
      chk("stall.sym_cnt", 32'(bus.sym_cnt), 5);
    end
    bus.in_valid = 1'b1;
    cyc("resume", 0, 1, 0, 0);
    cyc("resume", 3, 0, 1, 1);
    chk("resume.sym_cnt", 32'(bus.sym_cnt), 6);

    // Drop load at address 2: symbol completes, then idle
    bus.load = 1'b0;
    cyc("drop", 2, 0, 0, 0);
    cyc("drop", 1, 0, 0, 0);
    chk("drop.busy", 32'(bus.busy), 0);
    bus.load = 1'b1;
    cyc("reidle", 0, 0, 0, 0);
    cyc("rerun", 0, 1, 0, 0);
    cyc("rerun", 3, 0, 1, 0);
    cyc("rerun", 2, 0, 0, 0);
    cyc("rerun", 1, 0, 0, 0);
    cyc("rerun", 0, 1, 0, 0);
    cyc("rerun", 3, 0, 1, 1);

    // cfg_taps change while busy is ignored
    bus.cfg_taps = 4'd6;
    cyc("cfgbusy", 2, 0, 0, 0);
    cyc("cfgbusy", 1, 0, 0, 0);
    cyc("cfgbusy", 0, 1, 0, 0);
    cyc("cfgbusy", 3, 0, 1, 1);
    bus.load = 1'b0;
    cyc("cfgdrop", 2, 0, 0, 0);
    cyc("cfgdrop", 1, 0, 0, 0);
    chk("cfgdrop.busy", 32'(bus.busy), 0);
    bus.load = 1'b1;
    cyc("n6idle", 0, 0, 0, 0);
    cyc("n6", 0, 1, 0, 0);
    cyc("n6", 5, 0, 1, 0);
    cyc("n6", 4, 0, 0, 0);
    cyc("n6", 3, 0, 0, 0);
    cyc("n6", 2, 0, 0, 0);
    cyc("n6", 1, 0, 0, 0);
    cyc("n6", 0, 1, 0, 0);
    cyc("n6", 5, 0, 1, 1);
    cyc("n6", 4, 0, 0, 0);

    // Asynchronous reset mid-symbol at address 3
    chk("prerst.rd_addr", 32'(bus.rd_addr), 3);
    chk("prerst.busy", 32'(bus.busy), 1);
    rst = 1'b0;
    #1;
    chk_all_zero("asyncrst");
    @(posedge ffe_clk);
    #1;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.cfg_taps = 4'd1;
    chk("postrst.busy", 32'(bus.busy), 0);
    cyc("postrst", 0, 0, 0, 0);
    chk("postrst2.busy", 32'(bus.busy), 0);

    // N=1: shift and dump every cycle
    bus.load = 1'b1;
    cyc("n1idle", 0, 0, 0, 0);
    cyc("n1", 0, 1, 1, 0);
    cyc("n1", 0, 1, 1, 1);
    cyc("n1", 0, 1, 1, 1);
    chk("n1.sym_cnt", 32'(bus.sym_cnt), 3);
    bus.in_valid = 1'b0;
    cyc("n1stall", 0, 0, 0, 0);
    chk("n1stall.sym_cnt", 32'(bus.sym_cnt), 3);
    bus.in_valid = 1'b1;
    bus.load     = 1'b0;
    cyc("n1last", 0, 1, 1, 1);
    chk("n1last.busy", 32'(bus.busy), 0);
    chk("n1last.sym_cnt", 32'(bus.sym_cnt), 4);

    // cfg_taps=0 clamps to 8
    bus.cfg_taps = 4'd0;
    bus.load     = 1'b1;
    cyc("n0idle", 0, 0, 0, 0);
    cyc("n0", 0, 1, 0, 0);
    cyc("n0", 7, 0, 1, 0);
    for (int a = 6; a >= 1; a--) cyc("n0", a, 0, 0, 0);
    cyc("n0", 0, 1, 0, 0);
    cyc("n0", 7, 0, 1, 1);

    rst = 1'b0;
    #1;
    rst = 1'b1;

    // cfg_taps=9 clamps to 8
    bus.cfg_taps = 4'd9;
    cyc("n9idle", 0, 0, 0, 0);
    cyc("n9", 0, 1, 0, 0);
    cyc("n9", 7, 0, 1, 0);
    for (int a = 6; a >= 1; a--) cyc("n9", a, 0, 0, 0);
    cyc("n9", 0, 1, 0, 0);
    cyc("n9", 7, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
